fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Program-counter and fetch controller that drives the 256x9 instruction ROM address.
//  Selects one of four program segments packed into the single ROM image.
//  Sequences fetch through a Start/Done handshake with the testbench/top level.
//  Applies halt, stall and absolute/relative branch requests from the decoder.
// PARAMETERS
//  A_W         8    instruction address width (ROM depth = 2**A_W)
//  PROG0_BASE  0    start address of program segment 0
//  PROG1_BASE  64   start address of program segment 1
//  PROG2_BASE  128  start address of program segment 2
//  PROG3_BASE  192  start address of program segment 3
// PORTS
//  CLK           in   1    system clock, rising edge
//  Reset         in   1    asynchronous, active-high reset
//  Start         in   1    one-cycle request to begin the program chosen by ProgSel
//  ProgSel       in   2    program segment select, sampled only with accepted Start
//  Halt          in   1    current instruction is HALT
//  StallReq      in   1    hold PC this cycle (multi-cycle datapath op)
//  BranchEn      in   1    take branch this cycle
//  BranchRel     in   1    1 = PC-relative (BranchOffset), 0 = absolute (BranchTarget)
//  BranchTarget  in   A_W  absolute branch destination
//  BranchOffset  in   A_W  signed two's-complement relative offset
//  InstrAddress  out  A_W  registered PC; drives ROM address
//  Running       out  1    high while in RUN
//  Done          out  1    level; high in DONE until next accepted Start
//  Fault         out  1    sticky; PC overflowed/underflowed address space
//  CycleCount    out  16   RUN cycle count (present only with CYCLE_COUNT_EN)
// BEHAVIOUR
//  Reset (async, immediate, also mid-run): state=IDLE, InstrAddress=0, Running=0, Done=0, Fault=0, CycleCount=0.
//  FSM states: IDLE, RUN, DONE. All outputs are registered.
//  IDLE: Start=1 -> InstrAddress<=PROGn_BASE[ProgSel], state<=RUN. Otherwise hold.
//  RUN priority per cycle: Halt > StallReq > BranchEn > sequential increment.
//   Halt: InstrAddress holds, state<=DONE, Done<=1 next edge.
//   StallReq: InstrAddress holds; branch request ignored that cycle.
//   Branch abs: InstrAddress<=BranchTarget.
//   Branch rel: sum = {0,PC} + sign-extended offset in A_W+1 bits; out of range
//    (PC+off <0 or >2**A_W-1) -> Fault<=1, state<=DONE, PC holds. Else PC<=sum.
//   Increment: PC==2**A_W-1 -> Fault<=1, state<=DONE, PC holds; else PC<=PC+1.
//  Start during RUN ignored (no restart, ProgSel not sampled).
//  DONE: PC holds; Start=1 -> clear Done and Fault, load base, state<=RUN.
//  Latency: ROM read is combinational, so InstrOut for InstrAddress is valid the same
//   cycle; new PC visible 1 cycle after the request edge. First instruction of a program
//   is presented the cycle after Start is accepted.
//  Running==1 iff state==RUN; Done==1 iff state==DONE.
// CONFIGURATION
//  CYCLE_COUNT_EN defined: CycleCount port exists; cleared on accepted Start; +1 on
//   every RUN cycle incl. stalls and the Halt cycle; saturates at 16'hFFFF; holds in DONE/IDLE.
//  CYCLE_COUNT_EN undefined: CycleCount port and counter absent; all other behaviour identical.
// TESTING
//  Reset, Start with ProgSel=2 -> next cycle InstrAddress=128, Running=1; 3 idle cycles -> 131.
//  At PC=10, BranchEn, BranchRel=1, offset=8'hFB -> PC=5; abs target 200 -> PC=200.
//  StallReq+BranchEn at PC=40 -> PC stays 40; Halt+StallReq -> DONE, Done=1, PC=40.
//  PC=255 increment -> Fault=1, Done=1, PC=255; then Start ProgSel=0 -> Fault=0, PC=0.
//  Start pulsed while RUN at PC=70 -> ignored, PC=71; Reset asserted mid-run -> IDLE, PC=0 immediately.
//  CYCLE_COUNT_EN: Start, 5 RUN cycles incl. 1 stall, then Halt -> CycleCount=6, held in DONE.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch controller for the 256x9 instruction ROM.
// Selects one of four program segments on Start, then steps the PC each cycle,
// honouring halt, stall and absolute/relative branch requests from the decoder.
// Optional feature: define CYCLE_COUNT_EN to add the 16-bit saturating RUN-cycle
// counter on the CycleCount port.
module fetch_sequencer #(
  parameter int A_W        = 8,
  parameter int PROG0_BASE = 0,
  parameter int PROG1_BASE = 64,
  parameter int PROG2_BASE = 128,
  parameter int PROG3_BASE = 192
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic           Start,
  input  logic [1:0]     ProgSel,
  input  logic           Halt,
  input  logic           StallReq,
  input  logic           BranchEn,
  input  logic           BranchRel,
  input  logic [A_W-1:0] BranchTarget,
  input  logic [A_W-1:0] BranchOffset,
  output logic [A_W-1:0] InstrAddress,
  output logic           Running,
  output logic           Done,
  output logic           Fault
`ifdef CYCLE_COUNT_EN
  ,
  output logic [15:0]    CycleCount
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t state;

  // Segment start address for the selected program.
  function automatic logic [A_W-1:0] base_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    base_addr = A_W'(PROG0_BASE);
      2'd1:    base_addr = A_W'(PROG1_BASE);
      2'd2:    base_addr = A_W'(PROG2_BASE);
      default: base_addr = A_W'(PROG3_BASE);
    endcase
  endfunction

`ifdef CYCLE_COUNT_EN
  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Relative branch target in A_W+1 bits; the top bit is set exactly when the
  // result falls outside 0..2**A_W-1 (negative or past the top of the ROM).
  logic signed [A_W:0] rel_sum;
  logic                rel_oor;
  logic                pc_at_max;

  assign rel_sum   = $signed({1'b0, InstrAddress}) + $signed({BranchOffset[A_W-1], BranchOffset});
  assign rel_oor   = rel_sum[A_W];
  assign pc_at_max = (InstrAddress == {A_W{1'b1}});

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      InstrAddress <= '0;
      Running      <= 1'b0;
      Done         <= 1'b0;
      Fault        <= 1'b0;
`ifdef CYCLE_COUNT_EN
      CycleCount   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state        <= ST_RUN;
            InstrAddress <= base_addr(ProgSel);
            Running      <= 1'b1;
            Done         <= 1'b0;
            Fault        <= 1'b0;
`ifdef CYCLE_COUNT_EN
            CycleCount   <= '0;
`endif
          end
        end
        ST_RUN: begin
`ifdef CYCLE_COUNT_EN
          CycleCount <= sat_inc(CycleCount);
`endif
          if (Halt) begin
            state   <= ST_DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
          end else if (StallReq) begin
            // PC holds; a coincident branch request is dropped.
          end else if (BranchEn) begin
            if (!BranchRel) begin
              InstrAddress <= BranchTarget;
            end else if (rel_oor) begin
              state   <= ST_DONE;
              Running <= 1'b0;
              Done    <= 1'b1;
              Fault   <= 1'b1;
            end else begin
              InstrAddress <= rel_sum[A_W-1:0];
            end
          end else if (pc_at_max) begin
            state   <= ST_DONE;
            Running <= 1'b0;
            Done    <= 1'b1;
            Fault   <= 1'b1;
          end else begin
            InstrAddress <= InstrAddress + A_W'(1);
          end
        end
        default: begin
          state        <= ST_IDLE;
          InstrAddress <= '0;
          Running      <= 1'b0;
          Done         <= 1'b0;
          Fault        <= 1'b0;
        end
      endcase
    end
  end

endmodule
